// File: rtl/inst_queue.sv
// FIFO that holds fetched instructions between the IF and ID stages.
// Optional same-cycle IF-to-ID bypass on an empty queue: define INST_QUEUE_BYPASS_EN.
module inst_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [INST_W-1:0] if_inst_i,
  output logic              if_ready_o,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  input  logic              id_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic enq, deq, wr_en, rd_en, byp_active, byp_take;

  always_comb begin
    if_ready_o = !rst && (count_q < DEPTH_C);
    byp_active = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    byp_active = (count_q == '0) && if_valid_i && !flush_i && !rst;
`else
`endif
    id_valid_o = !rst && !flush_i && ((count_q != '0) || byp_active);

    // Invalid head is presented as an all-zero NOP bubble.
    id_pc_o   = '0;
    id_inst_o = '0;
    if (id_valid_o) begin
      if (byp_active) begin
        id_pc_o   = if_pc_i;
        id_inst_o = if_inst_i;
      end else begin
        id_pc_o   = pc_mem[rd_ptr_q];
        id_inst_o = inst_mem[rd_ptr_q];
      end
    end

    enq = if_valid_i && if_ready_o && !flush_i;
    deq = id_valid_o && id_ready_i;
    // A bypassed entry consumed by ID in the same cycle never touches storage.
    byp_take = byp_active && id_ready_i;
    wr_en    = enq && !byp_take;
    rd_en    = deq && !byp_take;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]   <= if_pc_i;
      inst_mem[wr_ptr_q] <= if_inst_i;
    end
  end

  assign count_o = count_q;

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter ADDR_W, default 32: PC width in bits.
REQ-002 Parameter INST_W, default 32: instruction width in bits.
REQ-003 Parameter DEPTH, default 4: entry count; power of two, minimum 2.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush_i  input  1  jump/branch redirect from EX; discards all contents.
REQ-007 if_valid_i  input  1  IF presents a fetched instruction.
REQ-008 if_pc_i  input  ADDR_W  PC of the fetched instruction.
REQ-009 if_inst_i  input  INST_W  fetched instruction word.
REQ-010 if_ready_o  output  1  queue can accept an entry this cycle.
REQ-011 id_valid_o  output  1  head entry is valid for ID.
REQ-012 id_pc_o  output  ADDR_W  head PC.
REQ-013 id_inst_o  output  INST_W  head instruction.
REQ-014 id_ready_i  input  1  ID consumes the head this cycle.
REQ-015 count_o  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-016 Circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0; occupancy counter is held separately.
REQ-017 Enqueue occurs when if_valid_i && if_ready_o && !flush_i; the entry is written at the write pointer on the clock edge.
REQ-018 Dequeue occurs when id_valid_o && id_ready_i; the read pointer advances on the clock edge.
REQ-019 if_ready_o = !rst && (count_o < DEPTH); it has no combinational dependence on id_ready_i.
REQ-020 When full, a same-cycle dequeue does not allow an enqueue in that cycle.
REQ-021 Simultaneous enqueue and dequeue when not empty and not full: count unchanged; both pointers advance.
REQ-022 id_valid_o = (count_o != 0) && !flush_i.
REQ-023 When id_valid_o = 0, id_pc_o and id_inst_o are all-zero, which is a NOP bubble.
REQ-024 Base latency: an entry enqueued at edge N is presented at the outputs in the cycle following edge N.
REQ-025 Ordering is strictly FIFO; entries are never duplicated or reordered.
REQ-026 flush_i = 1: on the next edge, count_o and both pointers become 0; any same-cycle enqueue and dequeue are discarded.
REQ-027 Flush has priority over enqueue and dequeue; reset has priority over flush.

Reset
REQ-028 rst = 1 at an edge sets count_o = 0, both pointers = 0, and id_valid_o = 0 with zero PC and instruction outputs after the edge.
REQ-029 While rst = 1: if_ready_o = 0 and id_valid_o = 0. Storage array contents are not reset.
REQ-030 Reset asserted mid-operation drops all entries, with the same result as flush.

Configuration
REQ-031 Macro INST_QUEUE_BYPASS_EN.
- Defined: when count_o = 0, if_valid_i = 1 and flush_i = 0, the outputs present if_pc_i/if_inst_i combinationally in the same cycle with id_valid_o = 1.
  - If id_ready_i = 1, the entry is consumed and not stored (count stays 0).
  - Otherwise the entry is stored normally.
- Not defined: no combinational IF-to-ID path; REQ-024 latency applies.

Verification
REQ-032 Reset, then fill: DEPTH = 4, id_ready_i = 0, four enqueues of PC 0x00, 0x04, 0x08, 0x0C -> count_o = 4, if_ready_o = 0, head PC 0x00.
REQ-033 Drain after fill: id_ready_i = 1 for 4 cycles -> outputs PC 0x00, 0x04, 0x08, 0x0C in order, then id_valid_o = 0 with zero PC and instruction.
REQ-034 Wrap-around: 10 streaming enqueue+dequeue cycles at count 2 -> count_o stays 2 and PC order is preserved across the pointer wrap.
REQ-035 Flush with enqueue: count 3, flush_i = 1 with if_valid_i = 1 (PC 0x40) -> id_valid_o = 0 that cycle, count_o = 0 next cycle, PC 0x40 never appears.
REQ-036 Full plus dequeue: count 4, id_ready_i = 1, if_valid_i = 1 (PC 0x50) -> count_o = 3 next cycle, PC 0x50 not accepted.
REQ-037 Bypass (macro defined): empty queue, if_valid_i = 1 with PC 0x80, id_ready_i = 1 -> id_pc_o = 0x80 the same cycle, count_o stays 0. Without the macro, PC 0x80 appears next cycle.
